// File: rtl/calc_alu_pkg.sv
// -----------------------------------------------------------------------------
// calc_alu_pkg
// Shared types and constants for the registered calculator ALU.
//   op_e     : 3-bit operation codes presented on the op port
//   FLAG_*   : bit positions inside the 4-bit {N,V,C,Z} flags word
//   state_e  : control FSM states of calc_alu_seq
// -----------------------------------------------------------------------------
package calc_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_OR  = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

  // IDLE: nothing pending, MUL: multiplier iterating, HOLD: result on output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/calc_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// calc_alu_mul_seq
// Unsigned shift-add multiplier, one multiplier bit per clock edge.
// Operands are captured on the edge where start is high; the following WIDTH
// edges each add one partial product.
//
// Ports
//   clk    in   1          rising-edge clock
//   rst    in   1          asynchronous, active-high reset (aborts any product)
//   start  in   1          load a/b and begin a new product
//   a      in   WIDTH      multiplicand
//   b      in   WIDTH      multiplier
//   done   out  1          high during the cycle whose closing edge adds the
//                          last partial product
//   prod   out  2*WIDTH    running sum including this cycle's partial product;
//                          equals the full product a*b while done is high
// -----------------------------------------------------------------------------
module calc_alu_mul_seq
  import calc_alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] step_sum;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;

    step_sum = sum_q + (mplier_q[0] ? mcand_q : '0);
    done     = busy_q && (cnt_q == CW'(1));
    prod     = step_sum;

    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      sum_d    = '0;
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      sum_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      busy_d   = !done;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/calc_alu_seq.sv
// -----------------------------------------------------------------------------
// calc_alu_seq
// Registered calculator ALU with valid/ready handshakes on both sides, an
// accumulator operand, {N,V,C,Z} status flags and an iterative multiply.
// Single-cycle ops produce their result on the accept edge; MUL produces it
// WIDTH edges after the accept edge.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operation presented
//   in_ready   out  1      operation accepted when in_valid && in_ready
//   op         in   3      operation code (calc_alu_pkg::op_e)
//   in1        in   WIDTH  operand A (ignored when use_acc=1)
//   in2        in   WIDTH  operand B (shift amount for SHL/SHR)
//   use_acc    in   1      take operand A from the accumulator
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      result consumed when out_valid && out_ready
//   result     out  WIDTH  result, low WIDTH bits
//   flags      out  4      {N,V,C,Z}
// -----------------------------------------------------------------------------
module calc_alu_seq
  import calc_alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;
  logic [WIDTH-1:0]       acc_q, acc_d;

  op_e                    op_in;
  logic [WIDTH-1:0]       opa;
  logic [WIDTH:0]         add_w;
  logic [WIDTH:0]         sub_w;
  logic [SHW-1:0]         shamt;
  logic                   shamt_oob;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c;
  logic                   alu_v;
  logic                   accept;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_prod;

  function automatic logic [NUM_FLAGS-1:0] make_flags(input logic [WIDTH-1:0] r,
                                                      input logic             c,
                                                      input logic             v);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_N] = r[WIDTH-1];
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Single-cycle datapath. Operand A is the accumulator value at accept time
  // when use_acc is set, which lets a result feed the next op directly.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_in     = op_e'(op);
    opa       = use_acc ? acc_q : in1;
    add_w     = {1'b0, opa} + {1'b0, in2};
    // The extra top bit of the widened difference is exactly the borrow (A<B).
    sub_w     = {1'b0, opa} - {1'b0, in2};
    shamt     = in2[SHW-1:0];
    shamt_oob = (32'(shamt) >= WIDTH);
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;

    unique case (op_in)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (opa[WIDTH-1] == in2[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (opa[WIDTH-1] != in2[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_AND: alu_res = opa & in2;
      OP_XOR: alu_res = opa ^ in2;
      OP_OR:  alu_res = opa | in2;
      OP_SHL: alu_res = shamt_oob ? '0 : (opa << shamt);
      OP_SHR: alu_res = shamt_oob ? '0 : (opa >> shamt);
      OP_MUL: alu_res = '0;  // produced by the iterative multiplier instead
      default: alu_res = '0;
    endcase
  end

  calc_alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (opa),
    .b     (in2),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // ---------------------------------------------------------------------------
  // Control FSM. A held result may be replaced on the same edge it is consumed,
  // so HOLD accepts a new op only when out_ready is also high.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    accept    = in_valid && in_ready;

    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    acc_d     = acc_q;
    mul_start = 1'b0;

    case (state_q)
      MUL: begin
        if (mul_done) begin
          result_d = mul_prod[WIDTH-1:0];
          flags_d  = make_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
          acc_d    = mul_prod[WIDTH-1:0];
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // accept is only possible in IDLE or HOLD, never alongside mul_done.
    if (accept) begin
      if (op_in == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = MUL;
      end else begin
        result_d  = alu_res;
        flags_d   = make_flags(alu_res, alu_c, alu_v);
        acc_d     = alu_res;
        state_d   = HOLD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_calc_alu_seq
// Directed self-checking bench for calc_alu_seq at WIDTH=5. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_calc_alu_seq;

  localparam int W = 5;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         use_acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  vec_t vecs [10];

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (result !== 5'd0) $display("FAIL rst_result got %0d exp 0", result); else n_pass++;
    n_checks++; if (flags !== 4'b0000) $display("FAIL rst_flags got %b exp 0000", flags); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_add();
    op = 3'b000; in1 = 5'd20; in2 = 5'd15; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL add_in_ready got %b exp 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL add_out_valid got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (result !== 5'd3) $display("FAIL add_result got %0d exp 3", result); else n_pass++;
    n_checks++; if (flags !== 4'b0010) $display("FAIL add_flags got %b exp 0010", flags); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL add_drain got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_sub_back_to_back();
    op = 3'b001; in1 = 5'd3; in2 = 5'd5; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    n_checks++; if (result !== 5'd30) $display("FAIL sub1_result got %0d exp 30", result); else n_pass++;
    n_checks++; if (flags !== 4'b1010) $display("FAIL sub1_flags got %b exp 1010", flags); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL sub1_in_ready got %b exp 1", in_ready); else n_pass++;
    in1 = 5'd16; in2 = 5'd1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL sub2_out_valid got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (result !== 5'd15) $display("FAIL sub2_result got %0d exp 15", result); else n_pass++;
    n_checks++; if (flags !== 4'b0100) $display("FAIL sub2_flags got %b exp 0100", flags); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL sub_drain got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_logic_shift();
    //            op      a      b      result flags{N,V,C,Z}
    vecs[0] = '{3'b010, 5'd12, 5'd10, 5'd8,  4'b0000}; // AND
    vecs[1] = '{3'b011, 5'd21, 5'd10, 5'd31, 4'b1000}; // XOR
    vecs[2] = '{3'b100, 5'd16, 5'd1,  5'd17, 4'b1000}; // OR
    vecs[3] = '{3'b101, 5'd3,  5'd9,  5'd6,  4'b0000}; // SHL, amount uses in2[2:0]=1
    vecs[4] = '{3'b110, 5'd31, 5'd2,  5'd7,  4'b0000}; // SHR
    vecs[5] = '{3'b110, 5'd31, 5'd7,  5'd0,  4'b0001}; // SHR by 7 >= WIDTH
    vecs[6] = '{3'b101, 5'd1,  5'd5,  5'd0,  4'b0001}; // SHL by exactly WIDTH
    vecs[7] = '{3'b101, 5'd1,  5'd4,  5'd16, 4'b1000}; // SHL to sign bit
    vecs[8] = '{3'b000, 5'd15, 5'd1,  5'd16, 4'b1100}; // ADD positive overflow
    vecs[9] = '{3'b000, 5'd16, 5'd16, 5'd0,  4'b0111}; // ADD negative overflow, carry, zero
    use_acc = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = vecs[i].op; in1 = vecs[i].a; in2 = vecs[i].b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (result !== vecs[i].r || flags !== vecs[i].f || out_valid !== 1'b1)
        $display("FAIL vec%0d got r=%0d f=%b v=%b exp r=%0d f=%b v=1",
                 i, result, flags, out_valid, vecs[i].r, vecs[i].f);
      else n_pass++;
      tick();
    end
  endtask

  task automatic mul_case(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_r, input logic [3:0] exp_f);
    op = 3'b111; in1 = a; in2 = b; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mul_%0dx%0d_accept got %b exp 1", a, b, in_ready); else n_pass++;
    tick();
    // Operand and op changes while iterating must not disturb the product.
    in_valid = 1'b0; op = 3'b000; in1 = 5'd31; in2 = 5'd31;
    for (int i = 0; i < W; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL mul_%0dx%0d_busy%0d got rdy=%b v=%b exp rdy=0 v=0", a, b, i, in_ready, out_valid);
      else n_pass++;
      tick();
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mul_%0dx%0d_valid got %b exp 1", a, b, out_valid); else n_pass++;
    n_checks++; if (result !== exp_r) $display("FAIL mul_%0dx%0d_result got %0d exp %0d", a, b, result, exp_r); else n_pass++;
    n_checks++; if (flags !== exp_f) $display("FAIL mul_%0dx%0d_flags got %b exp %b", a, b, flags, exp_f); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mul_%0dx%0d_drain got %b exp 0", a, b, out_valid); else n_pass++;
  endtask

  task automatic test_mul();
    mul_case(5'd7,  5'd6,  5'd10, 4'b0010);  // 42 -> 10, high bits nonzero
    mul_case(5'd3,  5'd5,  5'd15, 4'b0000);  // 15 fits, no carry
    mul_case(5'd31, 5'd31, 5'd1,  4'b0010);  // 961 = 30*32 + 1
  endtask

  task automatic test_hold();
    op = 3'b000; in1 = 5'd1; in2 = 5'd1; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    // Next op presented while the consumer stalls; it must wait.
    op = 3'b011; in1 = 5'd5; in2 = 5'd5;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || result !== 5'd2 || in_ready !== 1'b0)
        $display("FAIL hold%0d got v=%b r=%0d rdy=%b exp v=1 r=2 rdy=0", i, out_valid, result, in_ready);
      else n_pass++;
      tick();
    end
    n_checks++; if (flags !== 4'b0000) $display("FAIL hold_flags got %b exp 0000", flags); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL hold_release_ready got %b exp 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got %b exp 1", out_valid); else n_pass++;
    n_checks++; if (result !== 5'd0) $display("FAIL b2b_result got %0d exp 0", result); else n_pass++;
    n_checks++; if (flags !== 4'b0001) $display("FAIL b2b_flags got %b exp 0001", flags); else n_pass++;
    tick();
  endtask

  task automatic test_acc_chain();
    out_ready = 1'b1; use_acc = 1'b0;
    op = 3'b000; in1 = 5'd4; in2 = 5'd4; in_valid = 1'b1;
    tick();
    n_checks++; if (result !== 5'd8) $display("FAIL acc_add got %0d exp 8", result); else n_pass++;
    op = 3'b101; use_acc = 1'b1; in1 = 5'd31; in2 = 5'd2;
    tick();
    n_checks++; if (result !== 5'd0 || flags !== 4'b0001)
      $display("FAIL acc_shl got r=%0d f=%b exp r=0 f=0001", result, flags); else n_pass++;
    op = 3'b110; in2 = 5'd7;
    tick();
    n_checks++; if (result !== 5'd0 || flags !== 4'b0001)
      $display("FAIL acc_shr got r=%0d f=%b exp r=0 f=0001", result, flags); else n_pass++;
    // Second chain with nonzero values so a stale or wrong accumulator shows.
    op = 3'b000; use_acc = 1'b0; in1 = 5'd3; in2 = 5'd2;
    tick();
    op = 3'b001; use_acc = 1'b1; in1 = 5'd0; in2 = 5'd1;
    tick();
    n_checks++; if (result !== 5'd4) $display("FAIL acc_sub got %0d exp 4", result); else n_pass++;
    op = 3'b000; in2 = 5'd10;
    tick();
    in_valid = 1'b0; use_acc = 1'b0;
    n_checks++; if (result !== 5'd14) $display("FAIL acc_add2 got %0d exp 14", result); else n_pass++;
    tick();
  endtask

  task automatic test_rst_mid_mul();
    op = 3'b111; in1 = 5'd7; in2 = 5'd6; use_acc = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmul_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmul_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (result !== 5'd0 || flags !== 4'b0000)
      $display("FAIL rstmul_regs got r=%0d f=%b exp r=0 f=0000", result, flags); else n_pass++;
    #2;
    rst = 1'b0;
    tick();
    // Accumulator must have been cleared: 0 + 3.
    op = 3'b000; use_acc = 1'b1; in1 = 5'd31; in2 = 5'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; use_acc = 1'b0;
    n_checks++; if (result !== 5'd3 || flags !== 4'b0000)
      $display("FAIL rstmul_acc got r=%0d f=%b exp r=3 f=0000", result, flags); else n_pass++;
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (out_valid !== 1'b0 || result !== 5'd3)
      $display("FAIL rstmul_stray got v=%b r=%0d exp v=0 r=3", out_valid, result); else n_pass++;
    op = 3'b000; in1 = 5'd20; in2 = 5'd15; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++; if (result !== 5'd3 || flags !== 4'b0010 || out_valid !== 1'b1)
      $display("FAIL rstmul_add got r=%0d f=%b v=%b exp r=3 f=0010 v=1", result, flags, out_valid); else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 3'b000; in1 = '0; in2 = '0;
    use_acc = 1'b0; out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub_back_to_back();
    test_logic_shift();
    test_mul();
    test_hold();
    test_acc_chain();
    test_rst_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
